// File: rtl/output_buffer_drain.sv
// rtl/output_buffer_drain.sv - reads rows from the output buffer and streams them as 32-bit words
module output_buffer_drain #(
    parameter int ADDR_W = 6,
    parameter int ROW_W  = 512,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              buf_CEN,
    output logic              buf_WEN,
    output logic [ADDR_W-1:0] buf_A,
    output logic              buf_RETN,
    input  logic [ROW_W-1:0]  buf_Q,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int LANES  = ROW_W / WORD_W;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] ONE_LANE  = LANE_W'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_ROW   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   NO_ROWS   = '0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAPT,
        SEND
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W:0]     rows_left;
    logic [LANE_W-1:0]   lane;
    logic [ROW_W-1:0]    hold;
    logic [LANE_W-1:0]   lane_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                final_row;

    assign lane_next = lane + ONE_LANE;
    assign addr_next = cur_addr + ONE_ADDR;
    assign final_row = (rows_left == ONE_ROW);

    // Retention is released one cycle after reset drops and stays high from then on
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_RETN <= 1'b0;
        end else begin
            buf_RETN <= 1'b1;
        end
    end

    // Job FSM: one read strobe per row, capture the row, then serialise its lanes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cur_addr  <= '0;
            rows_left <= '0;
            lane      <= '0;
            hold      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            buf_CEN   <= 1'b1;
            buf_WEN   <= 1'b1;
            buf_A     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            done    <= 1'b0;
            buf_WEN <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_rows == NO_ROWS) begin
                            // Empty job: acknowledge without touching the buffer
                            done <= 1'b1;
                        end else begin
                            cur_addr  <= base_addr;
                            rows_left <= num_rows;
                            buf_CEN   <= 1'b0;
                            buf_A     <= base_addr;
                            busy      <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    buf_CEN <= 1'b1;
                    state   <= CAPT;
                end
                CAPT: begin
                    // Q is only valid for this one cycle, so the whole row is held locally
                    hold      <= buf_Q;
                    lane      <= '0;
                    out_valid <= 1'b1;
                    out_data  <= buf_Q[WORD_W-1:0];
                    out_last  <= final_row && (LAST_LANE == '0);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (lane == LAST_LANE) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            rows_left <= rows_left - ONE_ROW;
                            cur_addr  <= addr_next;
                            if (final_row) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                buf_CEN <= 1'b0;
                                buf_A   <= addr_next;
                                state   <= REQ;
                            end
                        end else begin
                            lane     <= lane_next;
                            out_data <= hold[lane_next*WORD_W +: WORD_W];
                            out_last <= final_row && (lane_next == LAST_LANE);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_buffer_drain.sv
// tb/tb_output_buffer_drain.sv - self-checking bench for output_buffer_drain
module tb_output_buffer_drain;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic [5:0]   base_addr;
    logic [6:0]   num_rows;
    logic         busy, done, buf_CEN, buf_WEN, buf_RETN;
    logic [5:0]   buf_A;
    logic [511:0] buf_Q;
    logic [31:0]  out_data;
    logic         out_valid, out_ready, out_last;

    output_buffer_drain dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .busy(busy), .done(done), .buf_CEN(buf_CEN), .buf_WEN(buf_WEN), .buf_A(buf_A),
        .buf_RETN(buf_RETN), .buf_Q(buf_Q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [511:0] mem [64];

    // Synchronous buffer model: data one cycle after a strobe, zero otherwise
    always @(posedge CLK) buf_Q <= (!buf_CEN) ? mem[buf_A] : '0;

    logic [31:0] got_data[$];
    bit          got_last[$];
    logic [5:0]  got_addr[$];
    int          done_cnt;
    int          wen_bad;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Stream/buffer monitor sampled on the falling edge
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(out_valid && out_data === prev_data && out_last === prev_last)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=0x%0h last=%0b expected valid=1 data=0x%0h last=%0b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            if (!buf_CEN) got_addr.push_back(buf_A);
            if (done) done_cnt++;
            if (buf_WEN !== 1'b1) wen_bad++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    function automatic logic pick_ready(input int mode, input int phase);
        case (mode)
            0:       return 1'b1;
            1:       return (phase % 4 == 0) || (phase % 4 == 3);
            default: return ($urandom % 4) != 0;
        endcase
    endfunction

    task automatic run_job(input logic [5:0] base, input logic [6:0] rows, input int mode,
                           input bit restart, input int exp_n);
        logic [31:0] exp_data[$];
        bit          exp_last[$];
        logic [5:0]  exp_addr[$];
        int n, first_v, busy_bad, bad, first_bad;
        bit seen;
        // Reference: rows*16 words, lane-major within row, addresses wrap mod 64
        for (int r = 0; r < int'(rows); r++) begin
            logic [5:0] a;
            a = 6'((int'(base) + r) % 64);
            exp_addr.push_back(a);
            for (int k = 0; k < 16; k++) begin
                exp_data.push_back(mem[a][32*k +: 32]);
                exp_last.push_back((r == int'(rows) - 1) && (k == 15));
            end
        end
        got_data.delete(); got_last.delete(); got_addr.delete();
        done_cnt = 0; wen_bad = 0;
        @(posedge CLK); #1;
        base_addr = base; num_rows = rows; start = 1'b1;
        out_ready = pick_ready(mode, 0);
        n = 0; first_v = 0; busy_bad = 0; seen = 1'b0;
        while (!seen && n < 5000) begin
            @(posedge CLK); #1;
            n++;
            start = restart && (n == 5);
            if (start) begin base_addr = 6'd40; num_rows = 7'd5; end
            out_ready = pick_ready(mode, n);
            if (out_valid && first_v == 0) first_v = n;
            if (done) begin
                seen = 1'b1;
                if (busy) busy_bad++;
            end else if (busy !== (rows != 0)) begin
                busy_bad++;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        if (exp_n != 0) check("job_cycles", n, exp_n);
        if (rows != 0) check("first_valid_latency", first_v, 3);
        check("busy_profile", busy_bad, 0);
        repeat (20) begin @(posedge CLK); #1; out_ready = 1'b1; end
        check("done_count", done_cnt, 1);
        check("wen_high", wen_bad, 0);
        check("word_count", got_data.size(), exp_data.size());
        check("addr_count", got_addr.size(), exp_addr.size());
        bad = 0; first_bad = -1;
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL word_order: %0d bad words, first at %0d got=0x%0h/%0b expected=0x%0h/%0b",
                     bad, first_bad, got_data[first_bad], got_last[first_bad],
                     exp_data[first_bad], exp_last[first_bad]);
        end
        bad = 0;
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            if (got_addr[i] !== exp_addr[i]) bad++;
        check("addr_order", bad, 0);
    endtask

    typedef struct {
        logic [5:0] base;
        logic [6:0] rows;
        int         mode;
        bit         restart;
        int         exp_n;
    } job_t;

    job_t jobs[7];

    initial begin
        jobs[0] = '{6'd5,  7'd1,  0, 1'b0, 19};
        jobs[1] = '{6'd62, 7'd3,  0, 1'b0, 55};
        jobs[2] = '{6'd9,  7'd1,  1, 1'b0, 0};
        jobs[3] = '{6'd30, 7'd0,  0, 1'b0, 1};
        jobs[4] = '{6'd20, 7'd2,  0, 1'b1, 37};
        jobs[5] = '{6'd17, 7'd64, 2, 1'b0, 0};
        jobs[6] = '{6'd63, 7'd2,  1, 1'b0, 0};

        for (int a = 0; a < 64; a++)
            for (int k = 0; k < 16; k++) mem[a][32*k +: 32] = $urandom;
        for (int k = 0; k < 16; k++) mem[5][32*k +: 32] = 32'h500 + k;

        RST = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b1;
        #2;
        check("rst_cen", buf_CEN, 1'b1);
        check("rst_wen", buf_WEN, 1'b1);
        check("rst_a", buf_A, 6'd0);
        check("rst_retn", buf_RETN, 1'b0);
        check("rst_outs", {out_valid, out_last, busy, done, out_data}, '0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        check("retn_after_reset", buf_RETN, 1'b1);

        for (int j = 0; j < 7; j++)
            run_job(jobs[j].base, jobs[j].rows, jobs[j].mode, jobs[j].restart, jobs[j].exp_n);

        for (int j = 0; j < 6; j++)
            run_job(6'($urandom_range(0, 63)), 7'($urandom_range(0, 6)), 2, 1'b0, 0);

        // Reset in the middle of a streaming row
        done_cnt = 0;
        @(posedge CLK); #1;
        base_addr = 6'd3; num_rows = 7'd4; start = 1'b1; out_ready = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        check("pre_reset_in_send", out_valid, 1'b1);
        RST = 1'b1;
        #1;
        check("mid_rst_cen", buf_CEN, 1'b1);
        check("mid_rst_a_retn", {buf_A, buf_RETN}, 7'd0);
        check("mid_rst_outs", {out_valid, out_last, busy, done, out_data}, '0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        check("no_done_after_abort", done_cnt, 0);
        check("idle_after_abort", {busy, out_valid, buf_CEN}, 3'b001);
        run_job(6'd0, 7'd1, 0, 1'b0, 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
